freq_bcd_autorange: RTL and testbench
=====================================

Name: freq_bcd_autorange

Overview:
- Downstream stage of the low-frequency counter. Consumes its 32-bit binary frequency result in milli-hertz (mHz) and converts it to BCD with a sequential double-dabble.
- Auto-ranges the result into a 4-digit fixed window with one-hot decimal-point position, for the 7-segment display multiplexer.
- Start/done handshake matches the counter's: the counter's o_done drives this block's i_start directly.

Parameters:
- IN_WIDTH, 32, binary input width; sets the shift-cycle count.
- NUM_BCD, 10, BCD digits held internally; must cover 2^IN_WIDTH-1.
- FRAC_DIGITS, 3, fractional digits in the input (mHz → 3).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous reset, active-low
- i_start  in  1  start pulse; honoured only while o_ready=1
- i_freq_mhz  in  IN_WIDTH  binary frequency in mHz; sampled on the accepted start
- o_bcd  out  16  4 display digits; [15:12] is the leftmost digit
- o_dp  out  4  one-hot decimal point, lit to the right of digit k (bit 3 = leftmost); 0 = none
- o_overflow  out  1  value ≥ 10000.000 Hz; display saturated
- o_ready  out  1  high in e_idle (combinational)
- o_done  out  1  one-cycle pulse when o_bcd/o_dp/o_overflow are updated

Behaviour:
- Reset (async, i_rst_n=0): state e_idle, o_bcd=0, o_dp=0, o_overflow=0, o_done=0, all internal registers cleared. Reset mid-operation aborts immediately; no o_done is issued.
- e_idle: o_ready=1. On i_start, latch i_freq_mhz into the shift register, clear the BCD register (NUM_BCD×4 bits), set bit counter = IN_WIDTH, go to e_conv. i_start in any other state is ignored.
- e_conv: each cycle, add 3 to every BCD digit ≥5, then shift {bcd,bin} left by 1 and decrement the counter. After IN_WIDTH cycles (32), go to e_norm with shift count k=0.
- Digits after conversion are D9..D0; D2..D0 are fractional.
- e_norm, evaluated once per cycle:
  - Overflow: any of D9..D7 nonzero.
  - Otherwise the window top index is t=6-k.
  - If overflow, or D6≠0, or k=3: finalise (below).
  - Else: shift the digit register left one digit (D0←0), k++, stay in e_norm.
- Finalise, in the same cycle as the decision:
  - Overflow: o_bcd=16'h9999, o_dp=0, o_overflow=1.
  - Otherwise: o_bcd = the original digits Dt..Dt-3 (the top four after normalisation), o_overflow=0.
  - o_dp by t: t=3 → 1000 (x.xxx); t=4 → 0100 (xx.xx); t=5 → 0010 (xxx.x); t=6 → 0000 (xxxx).
  - Truncation only; no rounding.
  - Then o_done=1 for that cycle and return to e_idle.
- Latency: start accepted in cycle 0; o_done in cycle 33+k, k∈{0..3}; o_ready is high again in the cycle after o_done.
- Outputs hold their last values until the next o_done; they never change mid-conversion.
- Input 0: displays 0.000 with o_dp=1000 (k=3).

Optional Feature:
- Macro: FREQ_BCD_ROUND_EN.
- Defined: finalise instead moves to e_round (one extra cycle; o_done moves there).
  - Guard digit = the digit just below the window (original Dt-4), present for t≥4; for t=3 the guard is 0.
  - If guard ≥5, BCD-increment the 4-digit window with carry.
  - Carry out with t<6: window becomes 1000 and t increases by one (e.g. 99.996 → 100.0, o_dp=0010).
  - Carry out with t=6: overflow (9999, o_dp=0, o_overflow=1).
  - Latency becomes 34+k.
- Not defined: e_round does not exist; behaviour is truncation as above.

Decomposition:
- Package freq_disp_pkg:
  - state typedef t_state {e_idle, e_conv, e_norm, e_round}
  - localparams DISP_DIGITS=4, FRAC_DIGITS default, OVF_DIGIT_LSB=7
- Sub-module bcd_dd_adjust: combinational per-digit add-3-if-≥5, instantiated NUM_BCD times by generate.

Test Plan:
- i_freq_mhz=1_234_567 → o_bcd=1234, o_dp=0000, ovf=0, o_done at cycle 33; with ROUND_EN → 1235 at cycle 34.
- 12_345 → k=2, o_bcd=1234, o_dp=0100, o_done at cycle 35; with ROUND_EN → 1235.
- 0 → o_bcd=0000, o_dp=1000, o_done at cycle 36; 9_999 → 9999, o_dp=1000.
- 10_000_000 → o_bcd=9999, o_dp=0000, o_overflow=1; a following 5_000 → 5000, o_dp=1000, overflow cleared.
- ROUND_EN: 99_996 → 1000, o_dp=0010; 9_999_600 → 9999, o_overflow=1. Without ROUND_EN: 9999 with o_dp=0100, and 9999 with o_dp=0000, overflow 0.
- i_start pulses during e_conv are ignored, with exactly one o_done. i_rst_n low at cycle 10 → outputs 0, no o_done, o_ready=1 after release; a new start completes normally.

Source files
------------

// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency display path (BCD conversion + auto-range).
package freq_disp_pkg;

  typedef enum logic [1:0] {e_idle, e_conv, e_norm, e_round} t_state;

  localparam int DISP_DIGITS     = 4;
  localparam int FRAC_DIGITS_DEF = 3;
  localparam int OVF_DIGIT_LSB   = 7;

  // Increment a 4-digit BCD window; bit 16 is the decimal carry out of the top digit.
  function automatic logic [16:0] bcd_inc4(input logic [15:0] w);
    logic [16:0] r;
    logic        c;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c && w[4*i +: 4] == 4'd9) begin
        r[4*i +: 4] = 4'd0;
        c = 1'b1;
      end else begin
        r[4*i +: 4] = w[4*i +: 4] + {3'b000, c};
        c = 1'b0;
      end
    end
    r[16] = c;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dd_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the next shift.
module bcd_dd_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/freq_bcd_autorange.sv
// mHz binary -> BCD (sequential double-dabble) and auto-range into a 4-digit display window.
// FREQ_BCD_ROUND_EN adds an e_round cycle that rounds on the digit below the window.
//
// state   | meaning
// e_idle  | waiting for i_start, o_ready high
// e_conv  | IN_WIDTH double-dabble shift cycles
// e_norm  | shift leading zero digits out until the window top digit is nonzero
// e_round | round on the guard digit and publish (FREQ_BCD_ROUND_EN only)
module freq_bcd_autorange
  import freq_disp_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int NUM_BCD     = 10,
  parameter int FRAC_DIGITS = FRAC_DIGITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [IN_WIDTH-1:0] i_freq_mhz,
  output logic [15:0]         o_bcd,
  output logic [3:0]          o_dp,
  output logic                o_overflow,
  output logic                o_ready,
  output logic                o_done
);

  localparam int BW      = NUM_BCD * 4;
  localparam int CW      = $clog2(IN_WIDTH + 1);
  localparam int KW      = $clog2(FRAC_DIGITS + 1);
  localparam int WIN_LSB = (OVF_DIGIT_LSB - DISP_DIGITS) * 4;

  t_state                 state;
  logic [IN_WIDTH-1:0]    bin_q;
  logic [BW-1:0]          bcd_q;
  logic [CW-1:0]          cnt_q;
  logic [KW-1:0]          k_q;
  logic [BW-1:0]          adj;
  logic [BW+IN_WIDTH-1:0] sh;
  logic [15:0]            win;
  logic                   ovf;

  for (genvar g = 0; g < NUM_BCD; g++) begin : g_adj
    bcd_dd_adjust u_adj (
      .d(bcd_q[4*g +: 4]),
      .q(adj[4*g +: 4])
    );
  end

  assign sh      = {adj, bin_q} << 1;
  assign ovf     = |bcd_q[BW-1:OVF_DIGIT_LSB*4];
  assign win     = bcd_q[WIN_LSB +: 16];
  assign o_ready = (state == e_idle);

  // k shifts put the window top at digit 6-k; dp sits right of the digit holding D3.
  function automatic logic [3:0] dp_of(input logic [KW-1:0] k);
    return (k == '0) ? 4'b0000 : 4'(4'b0001 << k);
  endfunction

`ifdef FREQ_BCD_ROUND_EN
  logic        ovf_q;
  logic [16:0] inc;
  logic [3:0]  guard;
  assign inc   = bcd_inc4(win);
  assign guard = bcd_q[WIN_LSB-4 +: 4];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= e_idle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      o_bcd      <= '0;
      o_dp       <= '0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
`ifdef FREQ_BCD_ROUND_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        e_idle: begin
          if (i_start) begin
            bin_q <= i_freq_mhz;
            bcd_q <= '0;
            cnt_q <= CW'(IN_WIDTH);
            state <= e_conv;
          end
        end
        e_conv: begin
          {bcd_q, bin_q} <= sh;
          cnt_q          <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            k_q   <= '0;
            state <= e_norm;
          end
        end
        e_norm: begin
          if (ovf || win[15:12] != 4'd0 || k_q == KW'(FRAC_DIGITS)) begin
`ifdef FREQ_BCD_ROUND_EN
            ovf_q <= ovf;
            state <= e_round;
`else
            if (ovf) begin
              o_bcd      <= 16'h9999;
              o_dp       <= 4'b0000;
              o_overflow <= 1'b1;
            end else begin
              o_bcd      <= win;
              o_dp       <= dp_of(k_q);
              o_overflow <= 1'b0;
            end
            o_done <= 1'b1;
            state  <= e_idle;
`endif
          end else begin
            bcd_q <= {bcd_q[BW-5:0], 4'h0};
            k_q   <= k_q + KW'(1);
          end
        end
`ifdef FREQ_BCD_ROUND_EN
        e_round: begin
          // A carry out of the window widens the range by one digit; at the top it saturates.
          if (ovf_q || (guard >= 4'd5 && inc[16] && k_q == '0)) begin
            o_bcd      <= 16'h9999;
            o_dp       <= 4'b0000;
            o_overflow <= 1'b1;
          end else if (guard >= 4'd5 && inc[16]) begin
            o_bcd      <= 16'h1000;
            o_dp       <= dp_of(k_q - KW'(1));
            o_overflow <= 1'b0;
          end else if (guard >= 4'd5) begin
            o_bcd      <= inc[15:0];
            o_dp       <= dp_of(k_q);
            o_overflow <= 1'b0;
          end else begin
            o_bcd      <= win;
            o_dp       <= dp_of(k_q);
            o_overflow <= 1'b0;
          end
          o_done <= 1'b1;
          state  <= e_idle;
        end
`endif
        default: state <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_bcd_autorange.sv
// Bench for freq_bcd_autorange: arithmetic reference model, directed and random values.
module tb_freq_bcd_autorange;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_freq_mhz;
  logic [15:0] o_bcd;
  logic [3:0]  o_dp;
  logic        o_overflow;
  logic        o_ready;
  logic        o_done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_bcd = '0;
  logic [3:0]  prev_dp  = '0;
  logic        prev_ovf = 1'b0;

  freq_bcd_autorange dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_freq_mhz(i_freq_mhz),
    .o_bcd(o_bcd),
    .o_dp(o_dp),
    .o_overflow(o_overflow),
    .o_ready(o_ready),
    .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input longint w);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((w / pow10(i)) % 10);
    return r;
  endfunction

  // Display value from plain decimal arithmetic on the mHz value.
  task automatic model(input longint v, output logic [15:0] bcd, output logic [3:0] dp,
                       output logic ovf, output int lat);
    int     t;
    longint win;
    ovf = (v >= 64'd10_000_000);
    if (v >= 64'd1_000_000)    t = 6;
    else if (v >= 64'd100_000) t = 5;
    else if (v >= 64'd10_000)  t = 4;
    else                       t = 3;
    lat = 33 + (6 - t);
    win = (v / pow10(t - 3)) % 10000;
`ifdef FREQ_BCD_ROUND_EN
    begin
      longint guard;
      lat   = lat + 1;
      guard = (t >= 4) ? (v / pow10(t - 4)) % 10 : 0;
      if (!ovf && guard >= 5) begin
        win = win + 1;
        if (win == 10000) begin
          if (t < 6) begin
            win = 1000;
            t   = t + 1;
          end else begin
            ovf = 1'b1;
          end
        end
      end
    end
`endif
    if (ovf) begin
      bcd = 16'h9999;
      dp  = 4'b0000;
    end else begin
      bcd = to_bcd(win);
      dp  = (t == 6) ? 4'b0000 : (t == 5) ? 4'b0010 : (t == 4) ? 4'b0100 : 4'b1000;
    end
  endtask

  task automatic do_conv(input logic [31:0] val, input bit poke, input string tag);
    logic [15:0] eb;
    logic [3:0]  ed;
    logic        eo;
    int          lat;
    int          first;
    int          dones;
    model({32'd0, val}, eb, ed, eo, lat);
    @(negedge i_clk);
    i_start    = 1'b1;
    i_freq_mhz = val;
    @(negedge i_clk);
    i_start    = 1'b0;
    i_freq_mhz = $urandom;
    first = -1;
    dones = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge i_clk);
      i_start = poke && (cyc == 5 || cyc == 17);
      if (o_done) begin
        dones++;
        if (first < 0) begin
          first = cyc;
          checks++;
          if (o_bcd !== eb || o_dp !== ed || o_overflow !== eo) begin
            failures++;
            $display("FAIL %s result val=%0d: got bcd=%h dp=%b ovf=%b want bcd=%h dp=%b ovf=%b",
                     tag, val, o_bcd, o_dp, o_overflow, eb, ed, eo);
          end
        end
      end else if (first < 0 && cyc == 20) begin
        checks++;
        if (o_bcd !== prev_bcd || o_dp !== prev_dp || o_overflow !== prev_ovf) begin
          failures++;
          $display("FAIL %s hold: got bcd=%h dp=%b ovf=%b want bcd=%h dp=%b ovf=%b",
                   tag, o_bcd, o_dp, o_overflow, prev_bcd, prev_dp, prev_ovf);
        end
      end
      if (first >= 0 && cyc == first + 1) begin
        checks++;
        if (o_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s ready_after_done: got %b want 1", tag, o_ready);
        end
      end
      if (first >= 0 && cyc >= first + 8) break;
    end
    i_start = 1'b0;
    checks++;
    if (first < 0) begin
      failures++;
      $display("FAIL %s timeout: no o_done within 80 cycles, want cycle %0d", tag, lat);
    end else if (first != lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", tag, first, lat);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL %s done_count: got %0d want 1", tag, dones);
    end
    prev_bcd = eb;
    prev_dp  = ed;
    prev_ovf = eo;
  endtask

  task automatic test_reset();
    checks++;
    if (o_bcd !== 16'h0 || o_dp !== 4'h0 || o_overflow !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: got bcd=%h dp=%b ovf=%b done=%b ready=%b want 0 0 0 0 1",
               o_bcd, o_dp, o_overflow, o_done, o_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vals [12];
    vals = '{32'd1_234_567, 32'd12_345, 32'd0, 32'd9_999, 32'd10_000_000, 32'd5_000,
             32'd99_996, 32'd9_999_600, 32'd10_000, 32'd999_999, 32'd9_999_999, 32'hFFFF_FFFF};
    foreach (vals[i]) do_conv(vals[i], 1'b0, "directed");
  endtask

  task automatic test_ignored_start();
    do_conv(32'd123_456, 1'b1, "ignored_start");
    do_conv(32'd7, 1'b1, "ignored_start");
  endtask

  task automatic test_reset_midway();
    int dones;
    @(negedge i_clk);
    i_start    = 1'b1;
    i_freq_mhz = 32'd1_234_567;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_bcd !== 16'h0 || o_dp !== 4'h0 || o_overflow !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_midway: got bcd=%h dp=%b ovf=%b done=%b ready=%b want 0 0 0 0 1",
               o_bcd, o_dp, o_overflow, o_done, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    checks++;
    if (dones != 0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_abort: got dones=%0d ready=%b want 0 1", dones, o_ready);
    end
    prev_bcd = '0;
    prev_dp  = '0;
    prev_ovf = 1'b0;
    do_conv(32'd12_345, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int n = 0; n < 30; n++) begin
      if (n % 5 == 4) v = $urandom;
      else v = 32'($urandom % 32'(pow10($urandom_range(1, 8))));
      do_conv(v, 1'b0, "random");
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_freq_mhz = '0;
    repeat (3) @(negedge i_clk);
    test_reset();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_midway();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
